// File: rtl/fc_util_pkg.sv
// Fibre Channel primitive types, ordered-set byte constants and decode helpers
// shared by the fc_prim_detect slice.
package fc_util;

  typedef enum logic [3:0] {
    PRIM_IDLE,
    PRIM_R_RDY,
    PRIM_SOFI3,
    PRIM_SOFN3,
    PRIM_EOFT,
    PRIM_EOFN,
    PRIM_EOFA,
    PRIM_NOS,
    PRIM_OLS,
    PRIM_LR,
    PRIM_LRR,
    PRIM_MAX
  } primitives_t;

  localparam logic [7:0]  FC_K28_5    = 8'hBC;
  localparam logic [3:0]  FC_OS_DATAK = 4'b1000;

  localparam logic [23:0] FC_IDLE_B   = 24'h95B5B5;
  localparam logic [23:0] FC_R_RDY_B  = 24'h954A4A;
  localparam logic [23:0] FC_SOFI3_B  = 24'hB55656;
  localparam logic [23:0] FC_SOFN3_B  = 24'hB53636;
  localparam logic [23:0] FC_NOS_B    = 24'h55BF45;
  localparam logic [23:0] FC_OLS_B    = 24'h358A55;
  localparam logic [23:0] FC_LR_B     = 24'h49BF49;
  localparam logic [23:0] FC_LRR_B    = 24'h35BF49;

  // EOF byte2 carries running disparity, so only the low two bytes identify the EOF
  localparam logic [7:0]  FC_EOF_RDN  = 8'h95;
  localparam logic [7:0]  FC_EOF_RDP  = 8'hB5;
  localparam logic [15:0] FC_EOFT_B   = 16'h7575;
  localparam logic [15:0] FC_EOFN_B   = 16'hD5D5;
  localparam logic [15:0] FC_EOFA_B   = 16'hF5F5;

  function automatic logic is_ordered_set(logic [31:0] data, logic [3:0] datak);
    return (datak == FC_OS_DATAK) && (data[31:24] == FC_K28_5);
  endfunction

  function automatic primitives_t fc_prim_decode(logic [31:0] data, logic [3:0] datak);
    primitives_t p;
    logic        eof_rd;
    p      = PRIM_MAX;
    eof_rd = (data[23:16] == FC_EOF_RDN) || (data[23:16] == FC_EOF_RDP);
    if (is_ordered_set(data, datak)) begin
      case (data[23:0])
        FC_IDLE_B:  p = PRIM_IDLE;
        FC_R_RDY_B: p = PRIM_R_RDY;
        FC_SOFI3_B: p = PRIM_SOFI3;
        FC_SOFN3_B: p = PRIM_SOFN3;
        FC_NOS_B:   p = PRIM_NOS;
        FC_OLS_B:   p = PRIM_OLS;
        FC_LR_B:    p = PRIM_LR;
        FC_LRR_B:   p = PRIM_LRR;
        default: begin
          if (eof_rd) begin
            case (data[15:0])
              FC_EOFT_B: p = PRIM_EOFT;
              FC_EOFN_B: p = PRIM_EOFN;
              FC_EOFA_B: p = PRIM_EOFA;
              default:   p = PRIM_MAX;
            endcase
          end
        end
      endcase
    end
    return p;
  endfunction

  function automatic logic is_prim_seq(primitives_t p);
    return (p == PRIM_NOS) || (p == PRIM_OLS) || (p == PRIM_LR) || (p == PRIM_LRR);
  endfunction

endpackage

// File: rtl/fc_prim_detect_seq_ch.sv
// One channel: registered ordered-set decode, run counter, sequence FSM and
// optional unknown-set error counter (FC_PRIM_ERR_CNT_EN).
//
//   state   | meaning
//   ST_NONE | no primitive sequence recognised
//   ST_SEQ  | seq_q holds the recognised NOS/OLS/LR/LRR
module fc_prim_seq_ch
  import fc_util::*;
#(
  parameter int SEQ_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        err_clr,
  output logic        prim_valid,
  output primitives_t prim,
  output logic        seq_valid,
  output primitives_t seq,
  output logic [15:0] err_cnt
);

  localparam int CW = $clog2(SEQ_COUNT + 1);
  localparam logic [CW-1:0] SEQ_MAX = CW'(SEQ_COUNT);

  typedef enum logic {ST_NONE, ST_SEQ} state_t;

  logic        os;
  primitives_t dec;
  logic        prim_valid_q;
  primitives_t prim_q, prim_d;
  primitives_t run_prim_q, run_prim_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t      state_q, state_d;
  primitives_t seq_q, seq_d;

  always_comb begin
    os         = is_ordered_set(in_data, in_datak);
    dec        = fc_prim_decode(in_data, in_datak);
    prim_d     = prim_q;
    run_prim_d = run_prim_q;
    cnt_d      = cnt_q;
    if (in_valid) begin
      if (!os) begin
        cnt_d = '0;
      end else if (dec == run_prim_q) begin
        prim_d = dec;
        cnt_d  = (cnt_q == SEQ_MAX) ? cnt_q : cnt_q + CW'(1);
      end else begin
        prim_d     = dec;
        run_prim_d = dec;
        cnt_d      = CW'(1);
      end
    end
  end

  // Recognition works off the registered run, which gives the two-cycle sequence latency
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    if (cnt_q == SEQ_MAX) begin
      if (is_prim_seq(run_prim_q)) begin
        state_d = ST_SEQ;
        seq_d   = run_prim_q;
      end else begin
        state_d = ST_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prim_valid_q <= 1'b0;
      prim_q       <= PRIM_IDLE;
      run_prim_q   <= PRIM_IDLE;
      cnt_q        <= '0;
      state_q      <= ST_NONE;
      seq_q        <= PRIM_IDLE;
    end else begin
      prim_valid_q <= in_valid && os;
      prim_q       <= prim_d;
      run_prim_q   <= run_prim_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      seq_q        <= seq_d;
    end
  end

  assign prim_valid = prim_valid_q;
  assign prim       = prim_q;
  assign seq_valid  = (state_q == ST_SEQ);
  assign seq        = seq_q;

`ifdef FC_PRIM_ERR_CNT_EN
  logic [15:0] err_q, err_d;
  logic        err_inc;

  always_comb begin
    err_inc = in_valid && os && (dec == PRIM_MAX);
    err_d   = err_q;
    if (err_clr) begin
      err_d = err_inc ? 16'd1 : 16'd0;
    end else if (err_inc && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: rtl/fc_prim_detect.sv
// Multi-channel FC ordered-set decoder / primitive-sequence recogniser; slices
// the buses into per-channel fc_prim_seq_ch instances (FC_PRIM_ERR_CNT_EN selects error counters).
module fc_prim_detect
  import fc_util::*;
#(
  parameter int NUM_CH    = 1,
  parameter int SEQ_COUNT = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*32-1:0]     in_data,
  input  logic [NUM_CH*4-1:0]      in_datak,
  output logic [NUM_CH-1:0]        prim_valid,
  output primitives_t [NUM_CH-1:0] prim,
  output logic [NUM_CH-1:0]        seq_valid,
  output primitives_t [NUM_CH-1:0] seq,
  input  logic [NUM_CH-1:0]        err_clr,
  output logic [NUM_CH*16-1:0]     err_cnt
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fc_prim_seq_ch #(
      .SEQ_COUNT(SEQ_COUNT)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid[c]),
      .in_data    (in_data[c*32 +: 32]),
      .in_datak   (in_datak[c*4 +: 4]),
      .err_clr    (err_clr[c]),
      .prim_valid (prim_valid[c]),
      .prim       (prim[c]),
      .seq_valid  (seq_valid[c]),
      .seq        (seq[c]),
      .err_cnt    (err_cnt[c*16 +: 16])
    );
  end

endmodule

// File: doc/fc_prim_detect.md
# fc_prim_detect

Multi-channel Fibre Channel ordered-set decoder and primitive-sequence recogniser. It sits after the transceiver word aligner and before the link-state and framing logic. Each channel classifies 32-bit ordered sets into `fc_util::primitives_t`. It also declares a primitive sequence (NOS, OLS, LR, LRR) once it has seen `SEQ_COUNT` consecutive identical sets.

## Interface
- `NUM_CH`, default 1: number of independent channels.
- `SEQ_COUNT`, default 3: number of consecutive identical sequence ordered sets required for recognition. Legal range is 2..15.
- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, `NUM_CH`: a word is present on that channel this cycle.
- `in_data`, in, `NUM_CH*32`: word per channel. Byte [31:24] is first on the wire.
- `in_datak`, in, `NUM_CH*4`: K-flags, one per byte.
- `prim_valid`, out, `NUM_CH`: the word on that channel was an ordered set (K28.5 in [31:24] with `datak=4'b1000`).
- `prim`, out, `NUM_CH` x `primitives_t`: the decoded primitive. `PRIM_MAX` means an unrecognised ordered set.
- `seq_valid`, out, `NUM_CH`: a primitive sequence is currently recognised.
- `seq`, out, `NUM_CH` x `primitives_t`: the recognised sequence (`PRIM_NOS`, `PRIM_OLS`, `PRIM_LR` or `PRIM_LRR`).
- `err_clr`, in, `NUM_CH`: clears the error counter. Used only under `FC_PRIM_ERR_CNT_EN`.
- `err_cnt`, out, `NUM_CH*16`: count of unrecognised ordered sets.

## Operation
- **Decode match rule.** A word matches only with `in_datak==4'b1000` and byte3 `0xBC`. Bytes [23:0] are then compared against the package table:
  - IDLE `95 B5 B5`
  - R_RDY `95 4A 4A`
  - SOFi3 `B5 56 56`
  - SOFn3 `B5 36 36`
  - EOFt `x5 75 75`
  - EOFn `x5 D5 D5`
  - EOFa `x5 F5 F5`
  - NOS `55 BF 45`
  - OLS `35 8A 55`
  - LR `49 BF 49`
  - LRR `35 BF 49`
- **EOF byte2.** In EOF entries, `x5` means byte2 is `0x95` or `0xB5` (either running disparity).
- **Unrecognised ordered sets.** Any other K28.5 ordered set gives `prim=PRIM_MAX`, `prim_valid=1`.
- **Non-ordered-set words.** Data words and malformed K patterns give `prim_valid=0`.
- **Run counter.** Each channel keeps a `run_prim` register and a run counter of width `$clog2(SEQ_COUNT+1)` that saturates at `SEQ_COUNT`. On each `in_valid`:
  - Ordered set equal to `run_prim`: increment the counter, saturating.
  - Ordered set different from `run_prim`: load `run_prim`, set the counter to 1.
  - Data word: clear the counter to 0.
- **Recognition states.** Each channel has two states, NONE and SEQ.
  - NONE → SEQ when the counter reaches `SEQ_COUNT` and `run_prim` is NOS, OLS, LR or LRR. `seq` latches `run_prim`.
  - SEQ → SEQ (switch) when a different sequence reaches `SEQ_COUNT`. `seq` updates in the same cycle.
  - SEQ → NONE when `run_prim` is a non-sequence primitive (IDLE, R_RDY, SOF*, EOF*, PRIM_MAX) and its counter reaches `SEQ_COUNT`.
  - Data words alone never exit SEQ.
- **Idle cycles.** Cycles with `in_valid=0` are ignored: registers hold and the run continues.
- **Channel independence.** Channels share no state.

## Timing
- **Decode latency.** `prim` and `prim_valid` are registered, so they appear 1 cycle after the input word.
- **Sequence latency.** `seq` and `seq_valid` appear 2 cycles after the input word that completes the count.
- **Output pulsing.** `prim_valid` pulses for one cycle per input word. `seq_valid` is a level.
- **Reset values.** `reset_n=0` at any clock edge sets, on every channel:
  - `prim_valid=0`, `prim=PRIM_IDLE`
  - `seq_valid=0`, `seq=PRIM_IDLE`
  - counter 0, state NONE, `err_cnt=0`
- **Reset mid-run.** Reset mid-run discards the partial run. After release, a full `SEQ_COUNT` run is needed again.

## Configuration
- **`FC_PRIM_ERR_CNT_EN` defined.** Each channel has a 16-bit counter that increments by 1 per `PRIM_MAX` result and saturates at `0xFFFF`.
  - `err_clr` is synchronous.
  - If `err_clr` and an increment occur in the same cycle, the counter loads 1.
- **`FC_PRIM_ERR_CNT_EN` undefined.** `err_cnt` is tied to 0 and `err_clr` is ignored. No counter flops are present.

## Structure
- **Additions to `fc_util`:**
  - byte constants for each table entry;
  - a function `fc_prim_decode(logic [31:0], logic [3:0]) -> primitives_t`;
  - a predicate `is_prim_seq(primitives_t)`.
- **Sub-module `fc_prim_seq_ch`.** One per channel, instantiated in a generate loop. It holds the decode register, run counter, state and optional error counter.
- **Top level.** Handles only slicing and concatenation.

## Test plan
- **Sequence recognition.** Ch0 receives NOS `BC55BF45` ×3 with `datak=1000`. `prim=PRIM_NOS` appears each cycle at +1. `seq_valid=1`, `seq=PRIM_NOS` at +2 after the third word, not earlier.
- **Broken run.** NOS, NOS, data word `0x12345678` (`datak=0`), NOS, NOS. `seq_valid` stays 0. A third NOS after that sets it.
- **Switch and exit.** From OLS recognised, send LR `BC49BF49` ×3: `seq` switches to `PRIM_LR` with `seq_valid` staying 1. Then IDLE `BC95B5B5` ×3: `seq_valid` drops to 0.
- **EOF and unknown.** EOFt with byte2 `0xB5` decodes as `PRIM_EOFT`. `BC123456` gives `PRIM_MAX`. With `FC_PRIM_ERR_CNT_EN` and `0xFFFE` preloaded by 0xFFFE unknown words, two more unknowns leave `err_cnt=0xFFFF`.
- **Reset and independence.** With `NUM_CH=2`, ch1 receives LRR ×2, then `reset_n=0` for 1 cycle, then LRR ×2: ch1 `seq_valid` stays 0. Ch0 OLS ×3 after reset is recognised.
